// File: rtl/binary_search_pkg.sv
// Shared constants and types for the maxima-table binary search.
package binary_search_pkg;

  localparam int unsigned N      = 16;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned DATA_W = 25;
  localparam int unsigned MAG_W  = 16;
  localparam int unsigned BIN_W  = 9;

  // One table entry: frequency bin on top, magnitude in the low bits.
  typedef struct packed {
    logic [BIN_W-1:0] bin;
    logic [MAG_W-1:0] mag;
  } maxima_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/binary_search.sv
// Sequential binary search over the sorted maxima table.
// Returns the largest index whose magnitude is strictly below the candidate
// magnitude (0 if none) and whether the candidate beats the smallest entry.
// Optional build macro: BINARY_SEARCH_BUSY_EN adds a registered busy output.
module binary_search
  import binary_search_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] maximas [N-1:0],
  input  logic              start,
  input  logic [DATA_W-1:0] current_number,
`ifdef BINARY_SEARCH_BUSY_EN
  output logic              busy,
`endif
  output logic              found,
  output logic              should_insert_in_maximas,
  output logic [IDX_W-1:0]  index_left,
  output logic [IDX_W-1:0]  index_right
);

  localparam int unsigned SUM_W = IDX_W + 1;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   lo_d, hi_d;
  logic [MAG_W-1:0]   key_q, key_d;
  logic               found_d;
  logic               insert_d;
  logic [SUM_W-1:0]   mid_sum;
  logic [IDX_W-1:0]   mid;
  logic               mid_less;
  logic               first_less;
  logic               unused_bins;

  // Upper midpoint of the live range and the two magnitude comparisons.
  always_comb begin
    mid_sum    = SUM_W'(index_left) + SUM_W'(index_right) + SUM_W'(1);
    mid        = mid_sum[SUM_W-1:1];
    mid_less   = maximas[mid][MAG_W-1:0] < key_q;
    first_less = maximas[0][MAG_W-1:0] < key_q;
  end

  // Bin fields take no part in the ordering.
  always_comb begin
    unused_bins = ^current_number[DATA_W-1:MAG_W];
    for (int i = 0; i < int'(N); i++) begin
      unused_bins = unused_bins ^ (^maximas[i][DATA_W-1:MAG_W]);
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    lo_d     = index_left;
    hi_d     = index_right;
    key_d    = key_q;
    found_d  = 1'b0;
    insert_d = should_insert_in_maximas;
    case (state_q)
      IDLE: begin
        if (start) begin
          key_d   = current_number[MAG_W-1:0];
          lo_d    = '0;
          hi_d    = IDX_W'(N - 1);
          state_d = SEARCH;
        end
      end
      SEARCH: begin
        if (index_left == index_right) begin
          state_d = DONE;
        end else if (mid_less) begin
          lo_d = mid;
        end else begin
          hi_d = mid - IDX_W'(1);
        end
      end
      DONE: begin
        found_d  = 1'b1;
        insert_d = first_less;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output registers; bounds drive the index outputs directly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_q                    <= '0;
      index_left               <= '0;
      index_right              <= '0;
      found                    <= 1'b0;
      should_insert_in_maximas <= 1'b0;
    end else begin
      key_q                    <= key_d;
      index_left               <= lo_d;
      index_right              <= hi_d;
      found                    <= found_d;
      should_insert_in_maximas <= insert_d;
    end
  end

`ifdef BINARY_SEARCH_BUSY_EN
  // Busy mirrors "not idle" one register stage from the next-state decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy <= 1'b0;
    else       busy <= (state_d != IDLE);
  end
`endif

endmodule

// File: tb/tb_binary_search.sv
// Self-checking bench for binary_search: directed cases plus randomized
// tables and keys against a counting reference model.
module tb_binary_search;
  import binary_search_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] maximas [N-1:0];
  logic              start;
  logic [DATA_W-1:0] current_number;
  logic              found;
  logic              should_insert_in_maximas;
  logic [IDX_W-1:0]  index_left;
  logic [IDX_W-1:0]  index_right;
`ifdef BINARY_SEARCH_BUSY_EN
  logic              busy;
`endif

  int vectors     = 0;
  int miscompares = 0;

  binary_search dut (
    .clk                      (clk),
    .reset                    (reset),
    .maximas                  (maximas),
    .start                    (start),
    .current_number           (current_number),
`ifdef BINARY_SEARCH_BUSY_EN
    .busy                     (busy),
`endif
    .found                    (found),
    .should_insert_in_maximas (should_insert_in_maximas),
    .index_left               (index_left),
    .index_right              (index_right)
  );

  always #5 clk = ~clk;

  // Count one comparison and report it if it disagrees.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] mk(input int bin, input int mag);
    maxima_t e;
    e.bin = BIN_W'(bin);
    e.mag = MAG_W'(mag);
    return e;
  endfunction

  // Reference: sorted table, so the answer is (#entries below key) - 1, floored at 0.
  function automatic int ref_index(input logic [DATA_W-1:0] cand);
    int cnt = 0;
    for (int i = 0; i < int'(N); i++)
      if (int'(maximas[i][MAG_W-1:0]) < int'(cand[MAG_W-1:0])) cnt++;
    return (cnt == 0) ? 0 : cnt - 1;
  endfunction

  function automatic bit ref_insert(input logic [DATA_W-1:0] cand);
    return int'(maximas[0][MAG_W-1:0]) < int'(cand[MAG_W-1:0]);
  endfunction

  task automatic set_ramp(input int step);
    for (int i = 0; i < int'(N); i++) maximas[i] = mk($urandom_range(0, 511), step * i);
  endtask

  task automatic set_const(input int v);
    for (int i = 0; i < int'(N); i++) maximas[i] = mk($urandom_range(0, 511), v);
  endtask

  task automatic set_random(input int maxv);
    int q[$];
    for (int i = 0; i < int'(N); i++) q.push_back(int'($urandom_range(0, maxv)));
    q.sort();
    for (int i = 0; i < int'(N); i++) maximas[i] = mk($urandom_range(0, 511), q[i]);
  endtask

  // One search; optionally fires a second start mid-search that must be ignored.
  task automatic run_search(input string tag, input logic [DATA_W-1:0] cand, input bit extra);
    int exp_idx;
    bit exp_ins;
    int first_k = 0;
    int pulses  = 0;
    exp_idx = ref_index(cand);
    exp_ins = ref_insert(cand);
    @(negedge clk);
    current_number = cand;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (found) begin
        pulses++;
        if (first_k == 0) begin
          first_k = k;
          check({tag, "_left"},   32'(index_left),  32'(exp_idx));
          check({tag, "_right"},  32'(index_right), 32'(exp_idx));
          check({tag, "_insert"}, 32'(should_insert_in_maximas), 32'(exp_ins));
        end
      end
      if (extra && k == 1) begin
        start = 1'b1;
        current_number = ~cand;
      end
      if (k == 2) start = 1'b0;
    end
    check({tag, "_pulses"},  32'(pulses), 32'd1);
    check({tag, "_latency"}, 32'(first_k >= 1 && first_k <= 6), 32'd1);
    check({tag, "_hold"},    32'(index_left), 32'(exp_idx));
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    current_number = '0;
    set_const(0);
    @(negedge clk);
    @(negedge clk);
    check("rst_found",  32'(found), 32'd0);
    check("rst_insert", 32'(should_insert_in_maximas), 32'd0);
    check("rst_left",   32'(index_left), 32'd0);
    check("rst_right",  32'(index_right), 32'd0);
    reset = 1'b0;

    set_const(0);
    run_search("zeros_key1", mk(0, 1), 1'b0);
    set_ramp(10);
    run_search("ramp_key55", mk(0, 55), 1'b0);
    run_search("ramp_key0", mk(0, 0), 1'b0);
    set_const(7);
    run_search("tie_key7", mk(3, 7), 1'b0);
    run_search("tie_key8", mk(3, 8), 1'b0);
    set_ramp(10);
    run_search("bin_max", mk(9'h1FF, 25), 1'b0);
    run_search("bin_zero", mk(0, 25), 1'b0);
    run_search("dbl_start", mk(0, 95), 1'b1);

    // Reset mid-search from a state where the outputs are non-zero.
    run_search("pre_reset", mk(0, 55), 1'b0);
    @(negedge clk);
    current_number = mk(0, 125);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_found",  32'(found), 32'd0);
    check("midrst_left",   32'(index_left), 32'd0);
    check("midrst_right",  32'(index_right), 32'd0);
    check("midrst_insert", 32'(should_insert_in_maximas), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    begin
      int stray = 0;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (found) stray++;
      end
      check("midrst_no_pulse", 32'(stray), 32'd0);
    end
    run_search("post_reset", mk(0, 125), 1'b0);

    // Randomized tables and keys; small ranges force ties and boundary keys.
    for (int t = 0; t < 40; t++) begin
      int maxv;
      int kmag;
      maxv = (t % 2 == 0) ? 20 : 60000;
      set_random(maxv);
      case ($urandom_range(0, 3))
        0: kmag = int'(maximas[$urandom_range(0, N - 1)][MAG_W-1:0]);
        1: kmag = int'(maximas[$urandom_range(0, N - 1)][MAG_W-1:0]) + 1;
        2: kmag = int'(maximas[0][MAG_W-1:0]);
        default: kmag = int'($urandom_range(0, maxv + 1));
      endcase
      if (kmag > 65535) kmag = 65535;
      run_search("rand", mk($urandom_range(0, 511), kmag), t % 5 == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/binary_search.md
Name: binary_search

Overview:
- Sequential binary search over a sorted table of 16 spectral maxima.
- Finds where a new candidate belongs in the table, and whether it qualifies for insertion at all.
- Sits inside the find_maximas block, between the FFT magnitude stream and the maxima-table update logic.
- Each entry and the candidate are packed as {bin[8:0], magnitude[15:0]}; only the magnitude is compared.

Parameters:
- N, 16, table depth; must be a power of two.
- IDX_W, 4, index width, log2(N).
- DATA_W, 25, entry width.
- MAG_W, 16, magnitude field width, bits [MAG_W-1:0] of an entry.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- maximas  in  N x DATA_W (unpacked [N-1:0])  table, sorted ascending by magnitude; entry 0 is smallest.
- start  in  1  one-cycle request; latches current_number.
- current_number  in  DATA_W  candidate {bin, magnitude}.
- found  out  1  one-cycle pulse: search complete, results valid.
- should_insert_in_maximas  out  1  candidate magnitude strictly greater than maximas[0] magnitude.
- index_left  out  IDX_W  lower search bound; the final position once found pulses.
- index_right  out  IDX_W  upper search bound; equals index_left once found pulses.

Behaviour:
- Reset (async): state=IDLE; found=0, should_insert_in_maximas=0, index_left=0, index_right=0; key register cleared.
- Key = magnitude field of the latched current_number. Compare "entry < key" uses unsigned magnitudes only; bin bits are ignored.
- IDLE:
  - On a clock edge with start=1: latch key, set lo=0, hi=N-1, go to SEARCH.
  - found stays 0.
- SEARCH, one iteration per cycle:
  - If lo==hi: go to DONE.
  - Otherwise mid=(lo+hi+1)>>1 (upper midpoint, computed IDX_W+1 bits wide).
  - If maximas[mid].mag < key then lo=mid, else hi=mid-1.
- DONE (one cycle):
  - found=1.
  - should_insert_in_maximas = (maximas[0].mag < key).
  - Return to IDLE.
- index_left/index_right continuously reflect lo/hi, so they are live during SEARCH.
- Final result index = largest i with maximas[i].mag < key, or 0 if none. should_insert_in_maximas=0 distinguishes the "none" case.
- Latency: at most log2(N)=4 SEARCH iterations. found is asserted at most 6 clock edges after the start edge.
- Outputs hold their last value after found until the next start. should_insert_in_maximas is updated only in DONE.
- Ties: equal magnitude is not "less"; the candidate is placed below equal entries. All-equal table with equal key gives index 0 and should_insert=0.
- start while in SEARCH/DONE: ignored, no queuing.
- maximas must remain stable from start until found. The block does not snapshot the table.
- Reset mid-search: immediate return to IDLE; no found pulse.

Optional Feature:
- BINARY_SEARCH_BUSY_EN defined: adds output port busy (1 bit), high in SEARCH and DONE, low in IDLE and in reset.
- Not defined: no busy port; behaviour otherwise identical.

Decomposition:
- Shared package binary_search_pkg:
  - constants N, IDX_W, DATA_W, MAG_W, BIN_W=9;
  - typedef maxima_t packed struct {bin[8:0], mag[15:0]};
  - enum state_t {IDLE, SEARCH, DONE}.
- No sub-module: the mux plus comparator is small enough to stay inline.

Test Plan:
- All entries 0, key {9'd0, mag 1}: found pulses after exactly 4 iterations; index_left=index_right=15; should_insert=1.
- Entries mag = 10*i (i=0..15), key 55: result index 5; should_insert=1.
- Entries mag = 10*i, key 0 and key 0 with maximas[0]=0: index 0, should_insert=0.
- Ties: all entries mag 7, key 7: index 0, should_insert=0. Same table, key 8: index 15, should_insert=1.
- Bin-field isolation: key bin=9'h1FF with small magnitude gives the same result as bin=0. A second start during SEARCH is ignored: exactly one found pulse, original key result.
- Assert reset mid-SEARCH: found, indexes and should_insert go to 0 immediately; no found pulse follows. A later start still works.
